// File: rtl/felica_reader_tx.sv
// Reader-side FeliCa / NFC-F frame transmitter.
// Sends preamble + SYNC + payload, Manchester-encoded at 212 or 424 kbps.
module felica_reader_tx #(
    parameter int unsigned PREAMBLE_BYTES = 6,
    parameter logic [15:0] SYNC_WORD      = 16'hB24D
) (
    input  logic       ck_1356meg,
    input  logic       rst_n,
    input  logic       speed,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       mod_out,
    output logic       tx_bit,
    output logic       done,
    output logic       err
);

    localparam logic [6:0] PRE_LAST = 7'(PREAMBLE_BYTES * 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_DATA,
        S_TAIL
    } state_t;

    state_t     state;
    logic       fast;
    logic [5:0] phase;
    logic [6:0] bit_cnt;
    logic [7:0] shift;
    logic       shift_last;
    logic [7:0] hold_data;
    logic       hold_last;

    logic [5:0] last_phase;
    logic [5:0] half;
    logic       bit_end;
    logic       byte_start;
    logic       load;
    logic       move;
    logic       underrun;
    logic       cur_bit;
    logic       enc;

    // tx_ready doubles as the "hold empty" flag
    always_comb begin
        last_phase = fast ? 6'd31 : 6'd63;
        half       = fast ? 6'd16 : 6'd32;
        bit_end    = (phase == last_phase);
        byte_start = (state == S_DATA) && (phase == 6'd0)
                     && (bit_cnt[2:0] == 3'd0);
        load       = tx_valid & tx_ready;
        move       = byte_start & ~tx_ready;
        underrun   = byte_start & tx_ready;
        cur_bit    = 1'b0;
        unique case (state)
            S_SYNC:  cur_bit = SYNC_WORD[~bit_cnt[3:0]];
            S_DATA:  cur_bit = move ? hold_data[7] : shift[7];
            default: cur_bit = 1'b0;
        endcase
        enc = (phase < half) ? cur_bit : ~cur_bit;
    end

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            fast       <= 1'b0;
            phase      <= 6'd0;
            bit_cnt    <= 7'd0;
            shift      <= 8'd0;
            shift_last <= 1'b0;
            hold_data  <= 8'd0;
            hold_last  <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            mod_out    <= 1'b0;
            tx_bit     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (load) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                tx_ready  <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    mod_out <= 1'b0;
                    tx_bit  <= 1'b0;
                    if (start) begin
                        // this edge already emits phase 0 of the first bit
                        fast    <= speed;
                        state   <= S_PRE;
                        busy    <= 1'b1;
                        phase   <= 6'd1;
                        bit_cnt <= 7'd0;
                    end
                end
                default: begin
                    if (underrun) begin
                        state    <= S_IDLE;
                        mod_out  <= 1'b0;
                        tx_bit   <= 1'b0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        tx_ready <= 1'b1;
                        phase    <= 6'd0;
                        bit_cnt  <= 7'd0;
                    end else begin
                        mod_out <= (state == S_TAIL) ? 1'b0 : enc;
                        tx_bit  <= cur_bit;
                        if (move) begin
                            shift      <= hold_data;
                            shift_last <= hold_last;
                            tx_ready   <= 1'b1;
                        end
                        phase <= bit_end ? 6'd0 : phase + 6'd1;
                        if (bit_end) begin
                            unique case (state)
                                S_PRE: begin
                                    if (bit_cnt == PRE_LAST) begin
                                        state   <= S_SYNC;
                                        bit_cnt <= 7'd0;
                                    end else begin
                                        bit_cnt <= bit_cnt + 7'd1;
                                    end
                                end
                                S_SYNC: begin
                                    if (bit_cnt == 7'd15) begin
                                        state   <= S_DATA;
                                        bit_cnt <= 7'd0;
                                    end else begin
                                        bit_cnt <= bit_cnt + 7'd1;
                                    end
                                end
                                S_DATA: begin
                                    shift <= {shift[6:0], 1'b0};
                                    if (bit_cnt[2:0] == 3'd7) begin
                                        bit_cnt <= 7'd0;
                                        if (shift_last) state <= S_TAIL;
                                    end else begin
                                        bit_cnt <= bit_cnt + 7'd1;
                                    end
                                end
                                default: begin
                                    state   <= S_IDLE;
                                    busy    <= 1'b0;
                                    done    <= 1'b1;
                                    bit_cnt <= 7'd0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_felica_reader_tx.sv
// Self-checking bench for felica_reader_tx: table of frames plus
// a per-cycle waveform scoreboard and hand-written reset sequence.
module tb_felica_reader_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       speed = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, mod_out, tx_bit, done, err;

    always #5 clk = ~clk;

    felica_reader_tx dut (
        .ck_1356meg (clk),
        .rst_n      (rst_n),
        .speed      (speed),
        .start      (start),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .mod_out    (mod_out),
        .tx_bit     (tx_bit),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        bit          spd;
        int          n;
        logic [23:0] bytes;
        int          end_at;
        bit          poke;
    } vec_t;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    int  bq[$];
    ev_t eq[$];
    vec_t vec[6];

    int pass_cnt = 0;
    int total_cnt = 0;

    int cyc = 0, per = 64, bad = 0, busy_drop = 0;
    int first_ready = 0, bitno = 0;
    bit active = 1'b0;
    bit prev_ready = 1'b1;

    function automatic void check(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endfunction

    // waveform monitor: cyc is the cycle number relative to the start edge
    always @(negedge clk) begin
        int c, p, sym, ex;
        ev_t e;
        if (!rst_n) begin
            active = 1'b0;
        end else if (active) begin
            cyc++;
            c = cyc - 1;
            p = c % per;
            if (bq.size() > 0) begin
                sym = bq[0];
                ex = (sym == 2) ? 0 : (p < per / 2) ? sym : 1 - sym;
                if (int'(mod_out) != ex) bad++;
                if (p == per - 1) begin
                    sym = bq.pop_front();
                    check($sformatf("bit%0d", bitno),
                          bad * 2 + int'(tx_bit), (sym == 2) ? 0 : sym);
                    bitno++;
                    bad = 0;
                end
            end
            if (!prev_ready && tx_ready && first_ready == 0)
                first_ready = cyc;
            if (done || err) begin
                if (eq.size() == 0) begin
                    check("end_expected", 1, 0);
                end else begin
                    e = eq.pop_front();
                    check("end_kind", int'(err) + 2 * int'(done && err), e.kind);
                    check("end_cycle", cyc, e.at);
                end
                check("end_state", int'(mod_out) + 2 * int'(busy)
                      + 4 * int'(bq.size() > 0) + 8 * int'(busy_drop > 0), 0);
                active = 1'b0;
            end else if (!busy) begin
                busy_drop++;
            end
        end else begin
            if (done || err) check("spurious_end", 1, 0);
            if (start) begin
                active = 1'b1;
                cyc = 0;
                per = speed ? 32 : 64;
                bad = 0;
                busy_drop = 0;
                first_ready = 0;
                bitno = 0;
            end
        end
        prev_ready = tx_ready;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic recover();
        rst_n = 1'b0;
        tick();
        bq.delete();
        eq.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic launch_vec(input vec_t v);
        logic [7:0]  b;
        logic [15:0] sw;
        sw = 16'hB24D;
        for (int i = 0; i < 48; i++) bq.push_back(0);
        for (int i = 0; i < 16; i++) bq.push_back(int'(sw[15-i]));
        for (int i = 0; i < v.n; i++) begin
            b = v.bytes[23-8*i -: 8];
            for (int j = 7; j >= 0; j--) bq.push_back(int'(b[j]));
        end
        if (v.n > 0) begin
            bq.push_back(2);
            eq.push_back('{0, v.end_at});
            tx_data = v.bytes[23:16];
            tx_last = (v.n == 1);
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            check("ready_after_preload", int'(tx_ready), 0);
        end else begin
            eq.push_back('{1, v.end_at});
        end
        speed = v.spd;
        start = 1'b1;
        tick();
        start = 1'b0;
        speed = ~v.spd;
    endtask

    task automatic run_vec(input vec_t v);
        int g, pp;
        pp = v.spd ? 32 : 64;
        launch_vec(v);
        for (int i = 1; i < v.n; i++) begin
            g = 0;
            while (!tx_ready && g < 20000) begin
                tick();
                g++;
            end
            check("refill_wait", int'(g >= 20000), 0);
            tx_data = v.bytes[23-8*i -: 8];
            tx_last = (i == v.n - 1);
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
        end
        if (v.poke) begin
            repeat (100) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        g = 0;
        while (active && g < 20000) begin
            tick();
            g++;
        end
        if (g >= 20000) begin
            check("frame_timeout", 1, 0);
            recover();
        end
        check("ready_rise_cycle", first_ready, (v.n > 0) ? 64 * pp + 1 : 0);
        repeat (10) tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        vec[0] = '{1'b0, 1, 24'h010000, 4672, 1'b0};
        vec[1] = '{1'b1, 1, 24'h010000, 2336, 1'b0};
        vec[2] = '{1'b0, 2, 24'hA53C00, 5184, 1'b0};
        vec[3] = '{1'b1, 3, 24'hFF005A, 2848, 1'b1};
        vec[4] = '{1'b0, 0, 24'h000000, 4097, 1'b0};
        vec[5] = '{1'b1, 0, 24'h000000, 2049, 1'b0};

        repeat (3) tick();
        check("rst_mod_out", int'(mod_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tx_bit", int'(tx_bit), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_tx_ready", int'(tx_ready), 1);
        rst_n = 1'b1;
        repeat (5) tick();

        for (int k = 0; k < 6; k++) run_vec(vec[k]);

        // reset in the middle of SYNC while modulating
        launch_vec(vec[0]);
        g = 0;
        while (cyc < 3080 && g < 5000) begin
            tick();
            g++;
        end
        check("pre_reset_mod", int'(mod_out), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_mod", int'(mod_out), 0);
        check("async_rst_ready", int'(tx_ready), 1);
        check("async_rst_busy", int'(busy), 0);
        bq.delete();
        eq.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        run_vec(vec[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
